// File: rtl/issue_queue_if.sv
// Issue queue bundle: dispatch, wakeup, arbiter and issue signals.
// The queue is the slave side; dispatch/arbiter/writeback form the master.
interface issue_queue_if #(
    parameter int OPCODE_WIDTH  = 7,
    parameter int AGE_WIDTH     = 5,
    parameter int PREG_WIDTH    = 6,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int WB_PORTS      = 2
) ();
    logic                                 flush;
    logic                                 dis_valid;
    logic                                 dis_ready;
    logic [OPCODE_WIDTH-1:0]              dis_op;
    logic [PREG_WIDTH-1:0]                dis_src1;
    logic [PREG_WIDTH-1:0]                dis_src2;
    logic                                 dis_src1_rdy;
    logic                                 dis_src2_rdy;
    logic [PREG_WIDTH-1:0]                dis_dst;
    logic [PAYLOAD_WIDTH-1:0]             dis_payload;
    logic [WB_PORTS-1:0]                  wb_valid;
    logic [WB_PORTS*PREG_WIDTH-1:0]       wb_tag;
    logic [15:0]                          iq_req;
    logic [15:0][OPCODE_WIDTH-1:0]        iq_op;
    logic [15:0][AGE_WIDTH-1:0]           iq_age;
    logic                                 grant;
    logic [3:0]                           grant_addr;
    logic                                 issue_valid;
    logic [OPCODE_WIDTH-1:0]              issue_op;
    logic [PREG_WIDTH-1:0]                issue_src1;
    logic [PREG_WIDTH-1:0]                issue_src2;
    logic [PREG_WIDTH-1:0]                issue_dst;
    logic [PAYLOAD_WIDTH-1:0]             issue_payload;
    logic [4:0]                           iq_count;

    modport slave (
        input  flush, dis_valid, dis_op, dis_src1, dis_src2,
        input  dis_src1_rdy, dis_src2_rdy, dis_dst, dis_payload,
        input  wb_valid, wb_tag, grant, grant_addr,
        output dis_ready, iq_req, iq_op, iq_age, iq_count,
        output issue_valid, issue_op, issue_src1, issue_src2,
        output issue_dst, issue_payload
    );

    modport master (
        output flush, dis_valid, dis_op, dis_src1, dis_src2,
        output dis_src1_rdy, dis_src2_rdy, dis_dst, dis_payload,
        output wb_valid, wb_tag, grant, grant_addr,
        input  dis_ready, iq_req, iq_op, iq_age, iq_count,
        input  issue_valid, issue_op, issue_src1, issue_src2,
        input  issue_dst, issue_payload
    );
endinterface

// File: rtl/issue_queue.sv
// 16-entry out-of-order issue queue with tag wakeup and dense age ordering.
// Ages stay a compact 0..count-1 sequence; issue closes the gap above it.
module issue_queue #(
    parameter int OPCODE_WIDTH  = 7,
    parameter int AGE_WIDTH     = 5,
    parameter int PREG_WIDTH    = 6,
    parameter int PAYLOAD_WIDTH = 64,
    parameter int WB_PORTS      = 2
) (
    input logic          clk,
    input logic          rst_n,
    issue_queue_if.slave iq
);
    localparam int N = 16;

    logic [N-1:0]             vld_q, vld_d;
    logic [N-1:0]             r1_q, r1_d;
    logic [N-1:0]             r2_q, r2_d;
    logic [OPCODE_WIDTH-1:0]  op_q   [N];
    logic [OPCODE_WIDTH-1:0]  op_d   [N];
    logic [PREG_WIDTH-1:0]    s1_q   [N];
    logic [PREG_WIDTH-1:0]    s1_d   [N];
    logic [PREG_WIDTH-1:0]    s2_q   [N];
    logic [PREG_WIDTH-1:0]    s2_d   [N];
    logic [PREG_WIDTH-1:0]    dst_q  [N];
    logic [PREG_WIDTH-1:0]    dst_d  [N];
    logic [PAYLOAD_WIDTH-1:0] pay_q  [N];
    logic [PAYLOAD_WIDTH-1:0] pay_d  [N];
    logic [AGE_WIDTH-1:0]     age_q  [N];
    logic [AGE_WIDTH-1:0]     age_d  [N];
    logic [4:0]               count_q, count_d;

    logic                     iv_q;
    logic [OPCODE_WIDTH-1:0]  iop_q;
    logic [PREG_WIDTH-1:0]    is1_q, is2_q, idst_q;
    logic [PAYLOAD_WIDTH-1:0] ipay_q;

    logic [N-1:0]             req;
    logic                     iss_fire;
    logic                     dis_fire;
    logic [3:0]               free_idx;
    logic [AGE_WIDTH-1:0]     iss_age;

    function automatic logic wake(
        input logic [WB_PORTS-1:0]            v,
        input logic [WB_PORTS*PREG_WIDTH-1:0] t,
        input logic [PREG_WIDTH-1:0]          s
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (v[k] && t[k*PREG_WIDTH +: PREG_WIDTH] == s) hit = 1'b1;
        end
        return hit;
    endfunction

    // Arbiter-facing view and fire conditions, from registered state only.
    always_comb begin
        req      = vld_q & r1_q & r2_q;
        iss_fire = iq.grant && req[iq.grant_addr] && !iq.flush;
        dis_fire = iq.dis_valid && (count_q != 5'd16) && !iq.flush;
        iss_age  = age_q[iq.grant_addr];
        free_idx = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = 4'(i);
        end
        iq.dis_ready = (count_q != 5'd16);
        iq.iq_req    = req;
        iq.iq_count  = count_q;
        iq.iq_op     = '0;
        iq.iq_age    = '0;
        for (int i = 0; i < N; i++) begin
            iq.iq_op[i]  = vld_q[i] ? op_q[i]  : '0;
            iq.iq_age[i] = vld_q[i] ? age_q[i] : '0;
        end
        iq.issue_valid   = iv_q;
        iq.issue_op      = iop_q;
        iq.issue_src1    = is1_q;
        iq.issue_src2    = is2_q;
        iq.issue_dst     = idst_q;
        iq.issue_payload = ipay_q;
    end

    // Entry next state: flush, wakeup, age compaction, free, allocate.
    always_comb begin
        vld_d   = vld_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dst_d   = dst_q;
        pay_d   = pay_q;
        age_d   = age_q;
        count_d = count_q;
        if (iq.flush) begin
            vld_d   = '0;
            r1_d    = '0;
            r2_d    = '0;
            count_d = '0;
            for (int i = 0; i < N; i++) age_d[i] = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vld_q[i]) begin
                    if (wake(iq.wb_valid, iq.wb_tag, s1_q[i])) r1_d[i] = 1'b1;
                    if (wake(iq.wb_valid, iq.wb_tag, s2_q[i])) r2_d[i] = 1'b1;
                    if (iss_fire && age_q[i] > iss_age)
                        age_d[i] = age_q[i] - 1'b1;
                end
            end
            if (iss_fire) begin
                vld_d[iq.grant_addr] = 1'b0;
                r1_d[iq.grant_addr]  = 1'b0;
                r2_d[iq.grant_addr]  = 1'b0;
                age_d[iq.grant_addr] = '0;
            end
            if (dis_fire) begin
                vld_d[free_idx] = 1'b1;
                op_d[free_idx]  = iq.dis_op;
                s1_d[free_idx]  = iq.dis_src1;
                s2_d[free_idx]  = iq.dis_src2;
                dst_d[free_idx] = iq.dis_dst;
                pay_d[free_idx] = iq.dis_payload;
                r1_d[free_idx]  = iq.dis_src1_rdy ||
                                  wake(iq.wb_valid, iq.wb_tag, iq.dis_src1);
                r2_d[free_idx]  = iq.dis_src2_rdy ||
                                  wake(iq.wb_valid, iq.wb_tag, iq.dis_src2);
                age_d[free_idx] = AGE_WIDTH'(count_q - 5'(iss_fire));
            end
            count_d = count_q + 5'(dis_fire) - 5'(iss_fire);
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) begin
                op_q[i]  <= '0;
                s1_q[i]  <= '0;
                s2_q[i]  <= '0;
                dst_q[i] <= '0;
                pay_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            count_q <= count_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dst_q   <= dst_d;
            pay_q   <= pay_d;
            age_q   <= age_d;
        end
    end

    // Issue port register: one-cycle pulse per accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q   <= 1'b0;
            iop_q  <= '0;
            is1_q  <= '0;
            is2_q  <= '0;
            idst_q <= '0;
            ipay_q <= '0;
        end else begin
            iv_q <= iss_fire;
            if (iss_fire) begin
                iop_q  <= op_q[iq.grant_addr];
                is1_q  <= s1_q[iq.grant_addr];
                is2_q  <= s2_q[iq.grant_addr];
                idst_q <= dst_q[iq.grant_addr];
                ipay_q <= pay_q[iq.grant_addr];
            end
        end
    end
endmodule

// File: doc/issue_queue.md
# issue_queue

16-entry out-of-order issue queue feeding the age-based issue arbiter. Accepts one renamed instruction per cycle from dispatch, tracks source-operand readiness through writeback tag broadcasts, and maintains a compact age per entry (0 = oldest). Presents per-entry op/request/age to the arbiter, and on grant retires the selected entry and registers it onto the issue port.

## Interface
Parameters:
- OPCODE_WIDTH, 7, opcode/op-class field width (matches arbiter)
- AGE_WIDTH, 5, age field width (matches arbiter)
- PREG_WIDTH, 6, physical register tag width
- PAYLOAD_WIDTH, 64, opaque payload (imm, pc, func bits)
- WB_PORTS, 2, number of wakeup broadcast ports

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries
- dis_valid  in  1  dispatch request
- dis_ready  out  1  queue can accept (count < 16)
- dis_op  in  OPCODE_WIDTH  opcode
- dis_src1, dis_src2  in  PREG_WIDTH  source tags
- dis_src1_rdy, dis_src2_rdy  in  1  source already available
- dis_dst  in  PREG_WIDTH  destination tag
- dis_payload  in  PAYLOAD_WIDTH  payload
- wb_valid  in  WB_PORTS  wakeup strobes
- wb_tag  in  WB_PORTS*PREG_WIDTH  wakeup tags, port k at [k*PREG_WIDTH +: PREG_WIDTH]
- iq_req  out  1 [15:0]  entry valid and both sources ready
- iq_op  out  OPCODE_WIDTH [15:0]  entry opcode
- iq_age  out  AGE_WIDTH [15:0]  entry age
- grant  in  1  arbiter grant
- grant_addr  in  4  granted entry index
- issue_valid  out  1  issued instruction valid
- issue_op, issue_src1, issue_src2, issue_dst, issue_payload  out  field widths  issued instruction
- iq_count  out  5  occupied entries (0..16)

## Operation
- Entry state: valid, op, src tags, two ready bits, dst, payload, age.
- Dispatch fires when dis_valid && dis_ready; writes the lowest-index invalid entry (using registered valid bits). dis_ready = (iq_count != 16), from registered count only; a same-cycle issue does not create room.
- New entry age = iq_count − (issue fires this cycle ? 1 : 0), so ages remain a dense 0..count−1 ordering.
- Wakeup: for every valid entry, srcN_rdy sets when any wb_valid[k] with wb_tag[k] == srcN. A wakeup also matches a dispatching instruction's sources in the same cycle (written ready). Ready bits never clear except by entry free.
- iq_req[i] = valid[i] & src1_rdy[i] & src2_rdy[i], from registered state only (wakeup visible next cycle). iq_op/iq_age driven from entry registers; invalid entries drive op 0, age 0.
- Issue fires when grant && iq_req[grant_addr]. Entry is cleared; every valid entry with age greater than the issued age decrements by 1; fields are registered onto the issue port. Grant to a non-requesting entry is ignored (no state change, issue_valid 0).
- iq_count_next = iq_count + dispatch − issue.
- Flush has priority over everything: all valid bits, ready bits and ages clear, iq_count → 0, same-cycle dispatch and grant discarded, issue_valid 0 next cycle.

## Timing
- Reset: all entries invalid, ages 0, iq_count 0, dis_ready 1, iq_req all 0, issue_valid 0, all issue fields 0.
- Dispatch at edge N → entry valid and visible on iq_* from N+1; iq_req earliest N+1 if both sources ready or woken at N.
- Wakeup at edge N → iq_req high from N+1.
- Grant seen in cycle N → issue_valid and fields valid in cycle N+1 (one-cycle latency), entry iq_req low in N+1; issue_valid is a single-cycle pulse per grant.
- Full (16): dis_ready 0; simultaneous issue frees the slot for the following cycle.
- Dispatch and issue in the same cycle: count unchanged; new age = count−1; freed slot not reused that cycle.
- rst_n assertion mid-operation clears state immediately, independent of clk.

## Test plan
- Reset, dispatch 3 instructions all-ready at entries 0,1,2 -> ages 0,1,2, iq_req=0x0007, iq_count=3.
- Dispatch entry with src1=5 not ready; wb_valid[0]=1, wb_tag=5 next cycle -> iq_req bit set one cycle after wakeup; wakeup coincident with dispatch -> ready at entry write.
- Grant addr 1 with entries ages 0,1,2 -> issue_valid next cycle with entry 1 fields; remaining ages 0,1; iq_count 2.
- Fill 16 entries -> dis_ready 0; grant + dis_valid same cycle -> dispatch rejected, dis_ready 1 next cycle, count 15; next dispatch gets age 15 in the freed slot.
- Grant to entry with unready source -> no issue_valid, state unchanged.
- Flush with grant and dispatch pending, and rst_n pulse mid-fill -> iq_count 0, iq_req 0, issue_valid 0.
